fft16_stage_sequencer: RTL and testbench

//   Control and data-buffer side of the 16-point radix-2 DIT FFT. Accepts 16 complex samples

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft16_operand_router.sv | 31 +++
 rtl/fft16_stage_sequencer.sv | 145 ++++++++++++++
 tb/tb_fft16_stage_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, constants and helpers for the 16-point radix-2 DIT FFT sequencer.
package fft_pkg;
    localparam int DATA_W = 16;
    localparam int NPT    = 16;
    localparam int LOG2N  = 4;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // W16^k = exp(-j*2*pi*k/16) in Q1.15, packed as {re, im}
    localparam logic [31:0] TW16 [8] = '{
        32'h7FFF_0000, 32'h7642_CF04, 32'h5A82_A57E, 32'h30FC_89BE,
        32'h0000_8000, 32'hCF04_89BE, 32'hA57E_A57E, 32'h89BE_CF04
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} seq_state_t;
endpackage

// File: rtl/fft16_operand_router.sv
// Maps a stage number to the buffer indices and twiddle index of each of the 8 butterflies.
module fft16_operand_router
    import fft_pkg::*;
(
    input  logic [1:0]      stage,
    output logic [7:0][3:0] lo_idx,
    output logic [7:0][3:0] hi_idx,
    output logic [7:0][2:0] tw_idx
);
    for (genvar gi = 0; gi < 8; gi++) begin : g_pair
        localparam logic [2:0] P = 3'(gi);
        logic [3:0] lo;
        logic [2:0] tw;

        // Lower index = pair number with a zero inserted at bit 'stage'.
        always_comb begin
            lo = '0;
            tw = '0;
            case (stage)
                2'd0:    begin lo = {P, 1'b0};               tw = 3'b000;          end
                2'd1:    begin lo = {P[2:1], 1'b0, P[0]};     tw = {P[0], 2'b00};   end
                2'd2:    begin lo = {P[2], 1'b0, P[1:0]};     tw = {P[1:0], 1'b0};  end
                default: begin lo = {1'b0, P};                tw = P;               end
            endcase
        end

        assign lo_idx[gi] = lo;
        assign hi_idx[gi] = lo | (4'd1 << stage);
        assign tw_idx[gi] = tw;
    end
endmodule

// File: rtl/fft16_stage_sequencer.sv
// Buffers a 16-sample frame in bit-reversed order, runs 4 in-place butterfly stages through
// an external 8-lane butterfly wrapper, then streams the bins out in natural order.
module fft16_stage_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NPT    = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_real,
    input  logic [DATA_W-1:0]     in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_imag,
    output logic                  out_last,
    output logic                  busy,
    output logic [16*DATA_W-1:0]  bf_in_real,
    output logic [16*DATA_W-1:0]  bf_in_imag,
    output logic [8*DATA_W-1:0]   bf_tw_real,
    output logic [8*DATA_W-1:0]   bf_tw_imag,
    input  logic [16*DATA_W-1:0]  bf_out_real,
    input  logic [16*DATA_W-1:0]  bf_out_imag
);
    if (NPT != 16) begin : g_npt_check
        $error("fft16_stage_sequencer only supports NPT == 16");
    end

    seq_state_t                  state_reg;
    logic [3:0]                  cnt_reg;
    logic [$clog2(LOG2N)-1:0]    stage_reg;
    logic                        in_ready_reg;
    logic                        out_valid_reg;
    logic                        out_last_reg;
    logic                        busy_reg;
    cplx_t                       mem [16];
    cplx_t                       cur;
    logic [7:0][3:0]             lo_idx;
    logic [7:0][3:0]             hi_idx;
    logic [7:0][2:0]             tw_idx;
    logic                        load_fire;
    logic                        computing;

    assign load_fire = (state_reg == LOAD) && in_valid && in_ready_reg;
    assign computing = (state_reg == COMPUTE);

    fft16_operand_router u_router (
        .stage  (stage_reg),
        .lo_idx (lo_idx),
        .hi_idx (hi_idx),
        .tw_idx (tw_idx)
    );

    // Butterfly operands are plain muxes of the buffer, forced to zero outside COMPUTE.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        cplx_t a;
        cplx_t b;
        cplx_t w;
        assign a = mem[lo_idx[gi]];
        assign b = mem[hi_idx[gi]];
        assign w = cplx_t'(TW16[tw_idx[gi]]);
        assign bf_in_real[2*DATA_W*gi +: DATA_W]          = computing ? a.re : '0;
        assign bf_in_imag[2*DATA_W*gi +: DATA_W]          = computing ? a.im : '0;
        assign bf_in_real[2*DATA_W*gi + DATA_W +: DATA_W] = computing ? b.re : '0;
        assign bf_in_imag[2*DATA_W*gi + DATA_W +: DATA_W] = computing ? b.im : '0;
        assign bf_tw_real[DATA_W*gi +: DATA_W]            = computing ? w.re : '0;
        assign bf_tw_imag[DATA_W*gi +: DATA_W]            = computing ? w.im : '0;
    end

    // Frame buffer has no reset; contents are don't-care until a frame is loaded.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[bitrev4(cnt_reg)] <= {in_real, in_imag};
        end else if (computing) begin
            for (int p = 0; p < 8; p++) begin
                mem[lo_idx[p]] <= {bf_out_real[2*DATA_W*p +: DATA_W],
                                   bf_out_imag[2*DATA_W*p +: DATA_W]};
                mem[hi_idx[p]] <= {bf_out_real[2*DATA_W*p + DATA_W +: DATA_W],
                                   bf_out_imag[2*DATA_W*p + DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= LOAD;
            cnt_reg       <= '0;
            stage_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_fire) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == 4'd15) begin
                            state_reg    <= COMPUTE;
                            stage_reg    <= '0;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    stage_reg <= stage_reg + 1'b1;
                    if (stage_reg == 2'd3) begin
                        state_reg     <= UNLOAD;
                        cnt_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        cnt_reg      <= cnt_reg + 1'b1;
                        out_last_reg <= (cnt_reg == 4'd14);
                        if (cnt_reg == 4'd15) begin
                            state_reg     <= LOAD;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign cur       = mem[cnt_reg];
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign out_real  = (state_reg == UNLOAD) ? cur.re : '0;
    assign out_imag  = (state_reg == UNLOAD) ? cur.im : '0;
endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Self-checking bench: sequencer plus a behavioural butterfly wrapper, scoreboarded against a golden FFT.
`timescale 1ns/1ps
module tb_fft16_stage_sequencer;
    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_real = '0;
    logic [15:0]  in_imag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_real;
    logic [15:0]  out_imag;
    logic         out_last;
    logic         busy;
    logic [255:0] bf_in_real;
    logic [255:0] bf_in_imag;
    logic [127:0] bf_tw_real;
    logic [127:0] bf_tw_imag;
    logic [255:0] bf_out_real;
    logic [255:0] bf_out_imag;

    always #5 clk = ~clk;

    fft16_stage_sequencer #(.DATA_W(16), .NPT(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_last    (out_last),
        .busy        (busy),
        .bf_in_real  (bf_in_real),
        .bf_in_imag  (bf_in_imag),
        .bf_tw_real  (bf_tw_real),
        .bf_tw_imag  (bf_tw_imag),
        .bf_out_real (bf_out_real),
        .bf_out_imag (bf_out_imag)
    );

    typedef int frame_t [16];
    typedef struct {
        int re;
        int im;
        bit last;
        int nr;
        int ni;
        int tol;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cycle = 0;
    int   bin_idx = 0;
    int   ready_mode = 0;
    int   tw_re [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    int   tw_im [8] = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    // Wrapper butterfly: out1 = a + W*b, out2 = a - W*b, Q1.15 product rounded, 16-bit wrap.
    function automatic logic [63:0] bfly(input int ar, input int ai, input int br, input int bi,
                                         input int wr, input int wi);
        longint pr;
        longint pi;
        int     tr;
        int     ti;
        int     o1r;
        int     o1i;
        int     o2r;
        int     o2i;
        pr  = longint'(br) * wr - longint'(bi) * wi;
        pi  = longint'(br) * wi + longint'(bi) * wr;
        tr  = int'((pr + 64'sd16384) >>> 15);
        ti  = int'((pi + 64'sd16384) >>> 15);
        o1r = ar + tr;
        o1i = ai + ti;
        o2r = ar - tr;
        o2i = ai - ti;
        return {o1r[15:0], o1i[15:0], o2r[15:0], o2i[15:0]};
    endfunction

    function automatic int bitrev(input int n);
        return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
    endfunction

    always_comb begin
        logic [63:0] r;
        r = '0;
        bf_out_real = '0;
        bf_out_imag = '0;
        for (int p = 0; p < 8; p++) begin
            r = bfly(int'($signed(bf_in_real[32*p +: 16])), int'($signed(bf_in_imag[32*p +: 16])),
                     int'($signed(bf_in_real[32*p+16 +: 16])), int'($signed(bf_in_imag[32*p+16 +: 16])),
                     int'($signed(bf_tw_real[16*p +: 16])), int'($signed(bf_tw_imag[16*p +: 16])));
            bf_out_real[32*p +: 16]    = r[63:48];
            bf_out_imag[32*p +: 16]    = r[47:32];
            bf_out_real[32*p+16 +: 16] = r[31:16];
            bf_out_imag[32*p+16 +: 16] = r[15:0];
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int nom, input int tol);
        int d;
        checks++;
        d = (act > nom) ? act - nom : nom - act;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, nom, tol);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int expv);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Golden radix-2 DIT FFT: natural-order loops over groups, same butterfly arithmetic.
    task automatic push_frame(input frame_t xr, input frame_t xi, input int nr, input int ni,
                              input int tol, input bit bin0_exact);
        int          ar [16];
        int          ai [16];
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            ar[bitrev(n)] = xr[n];
            ai[bitrev(n)] = xi[n];
        end
        for (int s = 0; s < 4; s++) begin
            int span;
            span = 1 << s;
            for (int base = 0; base < 16; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    int i;
                    int k;
                    i = base + j;
                    k = j * (8 >> s);
                    r = bfly(ar[i], ai[i], ar[i+span], ai[i+span], tw_re[k], tw_im[k]);
                    ar[i]      = sx16(int'(r[63:48]));
                    ai[i]      = sx16(int'(r[47:32]));
                    ar[i+span] = sx16(int'(r[31:16]));
                    ai[i+span] = sx16(int'(r[15:0]));
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back('{re: ar[k], im: ai[k], last: (k == 15), nr: nr, ni: ni,
                              tol: (bin0_exact && k == 0) ? -1 : tol});
        end
    endtask

    task automatic send_frame(input frame_t xr, input frame_t xi, input bit gaps, input bit hold);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (n < 16 && guard < 1000) begin
            @(posedge clk); #1;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_real  = 16'(xr[n]);
            in_imag  = 16'(xi[n]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                n++;
                if (n == 16) hs_cycle = cyc;
            end
            guard++;
        end
        if (n < 16) fail_now("send_timeout", n, 16);
        @(posedge clk); #1;
        in_valid = hold;
        in_real  = 16'h7777;
        in_imag  = 16'h1111;
    endtask

    task automatic hold_junk_until_idle();
        int guard;
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk); #1;
            in_real = in_real + 16'h0101;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 300) fail_now("hold_timeout", guard, 300);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) fail_now("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_out_real"}, int'(out_real), 0);
        chk({tag, "_out_imag"}, int'(out_imag), 0);
        chk({tag, "_bf_in_nz"}, int'(|{bf_in_real, bf_in_imag}), 0);
        chk({tag, "_bf_tw_nz"}, int'(|{bf_tw_real, bf_tw_imag}), 0);
    endtask

    // Monitor: pops and compares on every output handshake, checks stability under stall.
    initial begin
        logic [15:0] held_re;
        logic [15:0] held_im;
        logic        held_last;
        bit          stalled;
        bit          prev_valid;
        exp_t        e;
        held_re = '0;
        held_im = '0;
        held_last = 1'b0;
        stalled = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                exp_q.delete();
                bin_idx = 0;
                stalled = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (busy) chk("in_ready_busy", int'(in_ready), 0);
                if (stalled) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_re", int'(out_real), int'(held_re));
                    chk("stall_im", int'(out_imag), int'(held_im));
                    chk("stall_last", int'(out_last), int'(held_last));
                end
                if (out_valid && !prev_valid) chk("latency", cyc - hs_cycle, 5);
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_bin", bin_idx, -1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("bin %0d: re %0d im %0d last %0d", bin_idx,
                                 int'($signed(out_real)), int'($signed(out_imag)), out_last);
                        chk("bin_re", int'($signed(out_real)), e.re);
                        chk("bin_im", int'($signed(out_imag)), e.im);
                        chk("bin_last", int'(out_last), int'(e.last));
                        if (e.tol >= 0) begin
                            chk_tol("bin_re_nom", int'($signed(out_real)), e.nr, e.tol);
                            chk_tol("bin_im_nom", int'($signed(out_imag)), e.ni, e.tol);
                        end
                    end
                    if (out_last) begin
                        chk("hs_count", bin_idx + 1, 16);
                        bin_idx = 0;
                    end else begin
                        bin_idx++;
                    end
                end else if (out_valid) begin
                    stalled   = 1'b1;
                    held_re   = out_real;
                    held_im   = out_imag;
                    held_last = out_last;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Sink: always ready, or 1010.. with an extra 3-cycle stall on bin 7.
    initial begin
        int low7;
        bit tog;
        low7 = 0;
        tog = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
                low7 = 0;
                tog = 1'b1;
            end else if (out_valid && bin_idx == 7 && low7 < 3) begin
                out_ready = 1'b0;
                low7++;
            end else begin
                out_ready = tog;
                tog = ~tog;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t ramp_r, zero_i, imp_r, dc_r, pat_r, pat_i;
        for (int n = 0; n < 16; n++) begin
            ramp_r[n] = n + 1;
            zero_i[n] = 0;
            imp_r[n]  = (n == 0) ? 256 : 0;
            dc_r[n]   = 256;
            pat_r[n]  = n * 37 - 200;
            pat_i[n]  = 50 - n * 11;
        end

        #2 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        n_rst = 1'b1;

        // Ramp frame: routing on stage 0 and stage 3.
        push_frame(ramp_r, zero_i, 0, 0, -1, 1'b0);
        send_frame(ramp_r, zero_i, 1'b0, 1'b0);
        chk("rt_lane0_re", int'($signed(bf_in_real[0 +: 16])), 1);
        chk("rt_lane1_re", int'($signed(bf_in_real[16 +: 16])), 9);
        chk("rt_lane2_re", int'($signed(bf_in_real[32 +: 16])), 5);
        chk("rt_lane3_re", int'($signed(bf_in_real[48 +: 16])), 13);
        chk("rt_lane0_im", int'($signed(bf_in_imag[0 +: 16])), 0);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("tw_s0_re%0d", b), int'($signed(bf_tw_real[16*b +: 16])), 32767);
            chk($sformatf("tw_s0_im%0d", b), int'($signed(bf_tw_imag[16*b +: 16])), 0);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("tw_s3_re%0d", b), int'($signed(bf_tw_real[16*b +: 16])), tw_re[b]);
            chk($sformatf("tw_s3_im%0d", b), int'($signed(bf_tw_imag[16*b +: 16])), tw_im[b]);
        end
        wait_drain();

        // Impulse: flat spectrum.
        push_frame(imp_r, zero_i, 256, 0, 2, 1'b0);
        send_frame(imp_r, zero_i, 1'b0, 1'b0);
        wait_drain();

        // DC under backpressure.
        ready_mode = 1;
        push_frame(dc_r, zero_i, 0, 0, 4, 1'b1);
        send_frame(dc_r, zero_i, 1'b0, 1'b0);
        wait_drain();
        ready_mode = 0;

        // Random input gaps, in_valid held high with junk while busy.
        push_frame(pat_r, pat_i, 0, 0, -1, 1'b0);
        send_frame(pat_r, pat_i, 1'b1, 1'b1);
        hold_junk_until_idle();
        wait_drain();

        // Reset during stage 2.
        push_frame(ramp_r, zero_i, 0, 0, -1, 1'b0);
        send_frame(ramp_r, zero_i, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_s2");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        push_frame(pat_r, pat_i, 0, 0, -1, 1'b0);
        send_frame(pat_r, pat_i, 1'b0, 1'b0);
        wait_drain();

        // Reset while bin 5 is offered.
        begin
            int guard;
            push_frame(pat_r, pat_i, 0, 0, -1, 1'b0);
            send_frame(pat_r, pat_i, 1'b0, 1'b0);
            guard = 0;
            while (bin_idx != 5 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) fail_now("bin5_timeout", bin_idx, 5);
            n_rst = 1'b0;
            #1;
            check_reset_outputs("rst_ul");
            repeat (2) @(posedge clk);
            #1 n_rst = 1'b1;
        end
        push_frame(ramp_r, zero_i, 0, 0, -1, 1'b0);
        send_frame(ramp_r, zero_i, 1'b0, 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
